// File: rtl/video_timing_gen_if.sv
// Video timing generator signal bundle.
// The master side is the timing generator: it takes the run enable and the
// pixel returned by the frame source, and drives the read request plus the
// timed video outputs. The slave side is whatever sits around the generator
// (frame source and video sink).
interface video_timing_gen_if;
  logic       ien;
  logic       ord;
  logic [7:0] idata;
  logic [7:0] odata;
  logic       ovs;
  logic       ohs;
  logic       ode;
  logic       ofs;

  modport master (
    input  ien,
    input  idata,
    output ord,
    output odata,
    output ovs,
    output ohs,
    output ode,
    output ofs
  );

  modport slave (
    output ien,
    output idata,
    input  ord,
    input  odata,
    input  ovs,
    input  ohs,
    input  ode,
    input  ofs
  );
endinterface

// File: rtl/video_timing_gen.sv
// Video timing generator.
// A horizontal/vertical counter pair walks the frame (phase order within a
// line and within a frame: active, front porch, sync, back porch). The raw
// active flag is registered as the pixel read request ord; the frame source
// answers one clock later, and that answer is registered together with the
// delayed data enable, syncs and frame-start pulse, so every output on the
// video side lines up with ode.
// Optional feature: define VIDEO_TIMING_GEN_TEST_PATTERN_EN to replace the
// source pixel with (hcnt + vcnt) mod 256 of the pixel being shown; ord still
// toggles so the frame source sees the same request stream either way.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int POLARITY = 1
) (
  input  logic                iclk,
  input  logic                irst_n,
  video_timing_gen_if.master  vid
);

  // Frame geometry
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Sync windows are half-open: [start, end)
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Output levels of the sync pins
  localparam logic SYNC_ON  = (POLARITY != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Counters
  logic [HW-1:0] hcnt_reg;
  logic [VW-1:0] vcnt_reg;

  // Raw timing decoded from the counters
  logic active_raw;
  logic hsync_raw;
  logic vsync_raw;
  logic fstart_raw;

  // Stage 1: aligned with ord
  logic ord_reg;
  logic hs1_reg;
  logic vs1_reg;
  logic fs1_reg;

  // Stage 2: aligned with ode
  logic       ode_reg;
  logic       ohs_reg;
  logic       ovs_reg;
  logic       ofs_reg;
  logic [7:0] odata_reg;
  logic [7:0] pixel_next;

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  // Counter values carried alongside ord so the pattern matches ode
  logic [HW-1:0] hcnt_d_reg;
  logic [VW-1:0] vcnt_d_reg;
`endif

  // Pixel/line counters: free-run while enabled, parked at the origin when not
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (!vid.ien) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (hcnt_reg == H_LAST) begin
      hcnt_reg <= '0;
      if (vcnt_reg == V_LAST) begin
        vcnt_reg <= '0;
      end else begin
        vcnt_reg <= vcnt_reg + VW'(1);
      end
    end else begin
      hcnt_reg <= hcnt_reg + HW'(1);
    end
  end

  // Decode the current counter position into raw timing flags
  always_comb begin
    active_raw = (32'(hcnt_reg) < H_ACTIVE) && (32'(vcnt_reg) < V_ACTIVE);
    hsync_raw  = (32'(hcnt_reg) >= HS_START) && (32'(hcnt_reg) < HS_END);
    vsync_raw  = (32'(vcnt_reg) >= VS_START) && (32'(vcnt_reg) < VS_END);
    fstart_raw = (hcnt_reg == '0) && (vcnt_reg == '0);
  end

  // Stage 1: issue the read request and hold timing flags next to it;
  // dropping ien clears this stage on the very next edge
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ord_reg <= 1'b0;
      hs1_reg <= 1'b0;
      vs1_reg <= 1'b0;
      fs1_reg <= 1'b0;
    end else if (!vid.ien) begin
      ord_reg <= 1'b0;
      hs1_reg <= 1'b0;
      vs1_reg <= 1'b0;
      fs1_reg <= 1'b0;
    end else begin
      ord_reg <= active_raw;
      hs1_reg <= hsync_raw;
      vs1_reg <= vsync_raw;
      fs1_reg <= fstart_raw;
    end
  end

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  // Carry the counter position of the requested pixel into stage 1
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      hcnt_d_reg <= '0;
      vcnt_d_reg <= '0;
    end else if (!vid.ien) begin
      hcnt_d_reg <= '0;
      vcnt_d_reg <= '0;
    end else begin
      hcnt_d_reg <= hcnt_reg;
      vcnt_d_reg <= vcnt_reg;
    end
  end

  // Pixel value comes from the counters rather than the frame source
  always_comb begin
    pixel_next = 8'(32'(hcnt_d_reg) + 32'(vcnt_d_reg));
  end
`else
  // Pixel value is whatever the frame source returned for the request
  always_comb begin
    pixel_next = vid.idata;
  end
`endif

  // Stage 2: video outputs; this stage always follows stage 1 so one
  // in-flight pixel drains after ien drops, then everything sits idle
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ode_reg   <= 1'b0;
      ohs_reg   <= SYNC_OFF;
      ovs_reg   <= SYNC_OFF;
      ofs_reg   <= 1'b0;
      odata_reg <= 8'h00;
    end else begin
      ode_reg   <= ord_reg;
      ohs_reg   <= hs1_reg ? SYNC_ON : SYNC_OFF;
      ovs_reg   <= vs1_reg ? SYNC_ON : SYNC_OFF;
      ofs_reg   <= fs1_reg;
      odata_reg <= ord_reg ? pixel_next : 8'h00;
    end
  end

  assign vid.ord   = ord_reg;
  assign vid.ode   = ode_reg;
  assign vid.ohs   = ohs_reg;
  assign vid.ovs   = ovs_reg;
  assign vid.ofs   = ofs_reg;
  assign vid.odata = odata_reg;

endmodule
